// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the memory responder and future cache/arbiter blocks.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic {
    mem_op_read  = 1'b0,
    mem_op_write = 1'b1
  } lc3b_mem_op;

  localparam int LC3B_MAX_LATENCY = 15;

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// Memory request/response bundle between the LC-3b datapath (master) and a memory responder (slave).
interface lc3b_mem_responder_if;
  import lc3b_types::*;

  logic          mem_read;
  logic          mem_write;
  lc3b_word      mem_address;
  lc3b_word      mem_wdata;
  lc3b_mem_wmask mem_byte_enable;
  logic          mem_resp;
  lc3b_word      mem_rdata;
  logic          proto_err;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    input  mem_resp,
    input  mem_rdata,
    input  proto_err
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    output mem_resp,
    output mem_rdata,
    output proto_err
  );

endinterface

// File: rtl/lc3b_mem_array.sv
// 2^ADDR_BITS x 16 synchronous word array with per-byte write enables and an
// enabled, resettable read register (the register holds between reads).
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output lc3b_word             rdata_o,
  input  lc3b_mem_wmask        wr_be_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  lc3b_word             wdata_i
);

  localparam int DEPTH = 1 << ADDR_BITS;

  lc3b_word mem_q [0:DEPTH-1];
  lc3b_word rdata_q;

  // Byte-lane writes; the array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_be_i[0]) begin
      mem_q[wr_addr_i][7:0] <= wdata_i[7:0];
    end
    if (wr_be_i[1]) begin
      mem_q[wr_addr_i][15:8] <= wdata_i[15:8];
    end
  end

  // Read register: cleared by reset, loaded only when a read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 16'h0000;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[rd_addr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: latches a mem_read/mem_write request, waits LATENCY
// cycles, then completes it with a one-cycle mem_resp pulse.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input logic                 clk,
  input logic                 rst,
  lc3b_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  lc3b_mem_op           op_q, op_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  lc3b_word             wdata_q, wdata_d;
  lc3b_mem_wmask        be_q, be_d;
  logic                 resp_q, resp_d;
  logic                 perr_q, perr_d;

  logic                 req_s;
  logic [ADDR_BITS-1:0] word_addr_s;
  logic                 rd_en_s;
  logic [ADDR_BITS-1:0] rd_addr_s;
  lc3b_mem_wmask        wr_be_s;
  lc3b_word             rdata_s;
  logic                 unused_addr_s;

  assign req_s       = bus.mem_read | bus.mem_write;
  assign word_addr_s = bus.mem_address[ADDR_BITS:1];
  // Byte-select bit and aliased upper address bits are intentionally ignored.
  assign unused_addr_s = ^bus.mem_address;

  // Next-state, latch and array-control logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    perr_d    = perr_q;
    rd_en_s   = 1'b0;
    rd_addr_s = addr_q;
    wr_be_s   = 2'b00;

    case (state_q)
      IDLE: begin
        if (req_s) begin
          op_d    = bus.mem_write ? mem_op_write : mem_op_read;
          addr_d  = word_addr_s;
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_byte_enable;
          if (bus.mem_read && bus.mem_write) begin
            perr_d = 1'b1;
          end else begin
            perr_d = perr_q;
          end
          if (LATENCY == 1) begin
            // Zero-wait path: the array read must launch on the accepting edge.
            state_d   = RESP;
            cnt_d     = 4'd0;
            rd_en_s   = ~bus.mem_write;
            rd_addr_s = word_addr_s;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (!bus.mem_read && !bus.mem_write) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          if (bus.mem_write != (op_q == mem_op_write)) begin
            perr_d = 1'b1;
          end else begin
            perr_d = perr_q;
          end
          if (cnt_q <= 4'd1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            rd_en_s = (op_q == mem_op_read);
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
        if (!rst && (op_q == mem_op_write)) begin
          wr_be_s = be_q;
        end else begin
          wr_be_s = 2'b00;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    resp_d = (state_d == RESP);
  end

  // State and request latches with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= mem_op_read;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      resp_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      resp_q  <= resp_d;
      perr_q  <= perr_d;
    end
  end

  lc3b_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (rd_en_s),
    .rd_addr_i (rd_addr_s),
    .rdata_o   (rdata_s),
    .wr_be_i   (wr_be_s),
    .wr_addr_i (addr_q),
    .wdata_i   (wdata_q)
  );

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = rdata_s;
  assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: one LATENCY=3 and one LATENCY=1 instance against
// a word-array/response-schedule model, plus literal expectations.
module tb_lc3b_mem_responder;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lc3b_mem_responder_if if3 ();
  lc3b_mem_responder_if if1 ();

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int checks = 0;
  int errors = 0;

  int cyc      = 0;
  int last_rst = -1;
  bit rst_at_edge = 1'b0;
  bit started     = 1'b0;

  int          lat [2];
  int          exp_resp_cyc [2];
  bit          pend_is_read [2];
  logic [15:0] pend_rdata [2];
  logic [15:0] hold_rdata [2];
  int          perr_cyc [2];
  logic [15:0] mdl [2][256];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  function automatic logic get_resp(input int k);
    return (k == 0) ? if3.mem_resp : if1.mem_resp;
  endfunction

  function automatic logic [15:0] get_rdata(input int k);
    return (k == 0) ? if3.mem_rdata : if1.mem_rdata;
  endfunction

  function automatic logic get_perr(input int k);
    return (k == 0) ? if3.proto_err : if1.proto_err;
  endfunction

  task automatic drive(input int k, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    if (k == 0) begin
      if3.mem_read = rd; if3.mem_write = wr; if3.mem_address = a;
      if3.mem_wdata = d; if3.mem_byte_enable = be;
    end else begin
      if1.mem_read = rd; if1.mem_write = wr; if1.mem_address = a;
      if1.mem_wdata = d; if1.mem_byte_enable = be;
    end
  endtask

  // A violation sampled at the edge ending cycle tv is visible from cycle tv+1 until reset.
  task automatic note_perr(input int k, input int tv);
    if (!(perr_cyc[k] >= 0 && perr_cyc[k] > last_rst)) perr_cyc[k] = tv;
  endtask

  // One request; chg>0 changes rd/wr to rd2/wr2 at cycle T+chg (both low aborts).
  task automatic do_req(input int k, input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, input logic [1:0] be,
                        input int chg, input bit rd2, input bit wr2,
                        output logic [15:0] got_rdata, output logic got_resp);
    int t;
    int w;
    bit abort;
    @(negedge clk);
    drive(k, rd, wr, addr, data, be);
    t = cyc;
    w = int'(addr[8:1]);
    abort = (chg > 0) && !rd2 && !wr2;
    if (rd && wr) note_perr(k, t);
    if (chg > 0 && !abort && (wr2 != wr)) note_perr(k, t + chg);
    if (!abort) begin
      exp_resp_cyc[k] = t + lat[k];
      pend_is_read[k] = !wr;
      if (!wr) begin
        pend_rdata[k] = mdl[k][w];
      end else begin
        if (be[0]) mdl[k][w][7:0]  = data[7:0];
        if (be[1]) mdl[k][w][15:8] = data[15:8];
      end
    end
    for (int i = 1; i <= lat[k]; i++) begin
      @(negedge clk);
      if (i == chg) drive(k, rd2, wr2, addr, data, be);
    end
    got_rdata = get_rdata(k);
    got_resp  = get_resp(k);
    drive(k, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
  endtask

  // Cycle counter and reset bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= rst;
    if (rst) begin
      started  <= 1'b1;
      last_rst <= cyc;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin : cmp
    logic [15:0] exp_rd;
    logic        exp_rs;
    logic        exp_pe;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        exp_rs = (cyc == exp_resp_cyc[k]) && !rst_at_edge;
        exp_rd = hold_rdata[k];
        if (rst_at_edge) exp_rd = 16'h0000;
        else if (exp_rs && pend_is_read[k]) exp_rd = pend_rdata[k];
        exp_pe = (perr_cyc[k] >= 0) && (perr_cyc[k] > last_rst) && (perr_cyc[k] < cyc);
        check1($sformatf("resp_L%0d_c%0d", lat[k], cyc), get_resp(k), exp_rs);
        check16($sformatf("rdata_L%0d_c%0d", lat[k], cyc), get_rdata(k), exp_rd);
        check1($sformatf("perr_L%0d_c%0d", lat[k], cyc), get_perr(k), exp_pe);
        hold_rdata[k] <= exp_rd;
      end
    end
  end

  initial begin
    logic [15:0] rd;
    logic        rs;
    lat[0] = 3; lat[1] = 1;
    for (int k = 0; k < 2; k++) begin
      exp_resp_cyc[k] = -1;
      pend_is_read[k] = 1'b0;
      pend_rdata[k]   = 16'h0000;
      hold_rdata[k]   = 16'h0000;
      perr_cyc[k]     = -1;
      for (int a = 0; a < 256; a++) mdl[k][a] = 16'h0000;
      drive(k, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check1("reset_resp", if3.mem_resp, 1'b0);
    check16("reset_rdata", if3.mem_rdata, 16'h0000);
    check1("reset_perr", if3.proto_err, 1'b0);

    // Full write, read back, partial and empty byte masks.
    do_req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 0, 1'b0, 1'b0, rd, rs);
    check1("wr_beef_resp", rs, 1'b1);
    do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check16("rd_beef", rd, 16'hBEEF);
    do_req(0, 1'b0, 1'b1, 16'h0010, 16'h12AB, 2'b01, 0, 1'b0, 1'b0, rd, rs);
    do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 0, 1'b0, 1'b0, rd, rs);
    check16("rd_beab", rd, 16'hBEAB);
    check16("model_beab", mdl[0][8], 16'hBEAB);
    do_req(0, 1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check1("wr_be00_resp", rs, 1'b1);
    do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check16("rd_after_be00", rd, 16'hBEAB);
    do_req(0, 1'b1, 1'b0, 16'h0210, 16'h0000, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check16("rd_alias_0210", rd, 16'hBEAB);

    // Abort a write after one busy cycle.
    do_req(0, 1'b0, 1'b1, 16'h0010, 16'h1111, 2'b11, 1, 1'b0, 1'b0, rd, rs);
    check1("abort_no_resp", rs, 1'b0);
    do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check16("rd_after_abort", rd, 16'hBEAB);

    // Read and write together: serviced as a write, sticky protocol error.
    do_req(0, 1'b1, 1'b1, 16'h0030, 16'h0F0F, 2'b11, 0, 1'b0, 1'b0, rd, rs);
    check1("both_resp", rs, 1'b1);
    do_req(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check16("rd_after_both", rd, 16'h0F0F);
    check1("perr_sticky", if3.proto_err, 1'b1);

    // Reset during BUSY of a write.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0030, 16'hDEAD, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    check1("rst_busy_resp", if3.mem_resp, 1'b0);
    check16("rst_busy_rdata", if3.mem_rdata, 16'h0000);
    check1("rst_busy_perr", if3.proto_err, 1'b0);
    do_req(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check16("rd_after_rst", rd, 16'h0F0F);

    // Read turned into write mid-flight: latched read wins, error flagged.
    do_req(0, 1'b1, 1'b0, 16'h0030, 16'h5555, 2'b11, 1, 1'b0, 1'b1, rd, rs);
    check16("opchg_rdata", rd, 16'h0F0F);
    @(negedge clk);
    check1("opchg_perr", if3.proto_err, 1'b1);
    do_req(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check16("opchg_no_write", rd, 16'h0F0F);

    // LATENCY=1: write then back-to-back reads of the same word.
    do_req(1, 1'b0, 1'b1, 16'h0020, 16'h5A5A, 2'b11, 0, 1'b0, 1'b0, rd, rs);
    do_req(1, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check16("l1_rd_0020", rd, 16'h5A5A);
    do_req(1, 1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check16("l1_rd_0021", rd, 16'h5A5A);
    do_req(1, 1'b0, 1'b1, 16'h0020, 16'h7700, 2'b10, 0, 1'b0, 1'b0, rd, rs);
    do_req(1, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 0, 1'b0, 1'b0, rd, rs);
    check16("l1_rd_hi_byte", rd, 16'h775A);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
